// File: rtl/mesi_snoop_ctrl.sv
// Bus-snooping MESI coherence controller: round-robin arbitration, then one
// snoop/write-back/done sequence per transaction for NUM_CACHES caches.
module mesi_snoop_ctrl #(
  parameter int NUM_CACHES = 4
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [NUM_CACHES-1:0]   Request,
  input  logic [NUM_CACHES-1:0]   WriteRead,
  input  logic [3*NUM_CACHES-1:0] State,
  output logic [NUM_CACHES-1:0]   Grant,
  output logic                    Busy,
  output logic [2:0]              bus,
  output logic [3*NUM_CACHES-1:0] NewState,
  output logic [NUM_CACHES-1:0]   WriteBack,
  output logic                    Hit,
  output logic                    Miss,
  output logic                    Done
);

  localparam int IW = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;

  localparam logic [2:0] ST_I = 3'b001, ST_S = 3'b010, ST_M = 3'b011, ST_E = 3'b100;
  localparam logic [2:0] BUS_NONE = 3'b000, BUS_RD = 3'b001, BUS_RDX = 3'b010,
                         BUS_UPGR = 3'b011;

  typedef enum logic [1:0] {IDLE, SNOOP, WB, DONE} fsm_t;

  fsm_t fsm_q, fsm_d;

  logic [IW-1:0]           rr_ptr, win_q, win_d, cand;
  logic [NUM_CACHES-1:0]   wr_q;
  logic [3*NUM_CACHES-1:0] st_q;
  logic [3*NUM_CACHES-1:0] ns_q, ns_d;
  logic [NUM_CACHES-1:0]   wb_q, wb_d;
  logic                    hit_q, miss_q, hit_d, miss_d;
  logic                    found, req_wr, others_valid;
  logic [2:0]              req_st, req_ns, cmd;

  // Unknown encodings collapse to I so every later decision sees a legal state.
  function automatic logic [2:0] norm(input logic [2:0] s);
    case (s)
      ST_S, ST_M, ST_E: return s;
      default:          return ST_I;
    endcase
  endfunction

  // Returns {writeback, next_state} for a non-requesting cache.
  function automatic logic [3:0] snoop_other(input logic [2:0] c, input logic [2:0] s);
    case (c)
      BUS_RD:   return (s == ST_E) ? {1'b0, ST_S} :
                       (s == ST_M) ? {1'b1, ST_S} : {1'b0, s};
      BUS_RDX:  return {(s == ST_M), ST_I};
      BUS_UPGR: return (s == ST_S) ? {1'b0, ST_I} : {1'b0, s};
      default:  return {1'b0, s};
    endcase
  endfunction

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    win_d = rr_ptr;
    found = 1'b0;
    cand  = rr_ptr;
    for (int k = 0; k < NUM_CACHES; k++) begin
      cand = (cand == IW'(NUM_CACHES - 1)) ? '0 : cand + 1'b1;
      if (!found && Request[cand]) begin
        win_d = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    req_st       = ST_I;
    req_wr       = 1'b0;
    others_valid = 1'b0;
    for (int i = 0; i < NUM_CACHES; i++) begin
      if (IW'(i) == win_q) begin
        req_st = norm(st_q[3*i +: 3]);
        req_wr = wr_q[i];
      end else if (norm(st_q[3*i +: 3]) != ST_I) begin
        others_valid = 1'b1;
      end
    end

    cmd    = BUS_NONE;
    req_ns = req_st;
    hit_d  = 1'b1;
    miss_d = 1'b0;
    case (req_st)
      ST_E: req_ns = req_wr ? ST_M : ST_E;
      ST_S: if (req_wr) begin
        req_ns = ST_M;
        cmd    = BUS_UPGR;
        hit_d  = 1'b0;
        miss_d = 1'b1;
      end
      ST_M: req_ns = ST_M;
      default: begin
        req_ns = req_wr ? ST_M : (others_valid ? ST_S : ST_E);
        cmd    = req_wr ? BUS_RDX : BUS_RD;
        hit_d  = 1'b0;
        miss_d = 1'b1;
      end
    endcase

    ns_d = '0;
    wb_d = '0;
    for (int i = 0; i < NUM_CACHES; i++) begin
      if (IW'(i) == win_q) begin
        ns_d[3*i +: 3] = req_ns;
      end else begin
        {wb_d[i], ns_d[3*i +: 3]} = snoop_other(cmd, norm(st_q[3*i +: 3]));
      end
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (|Request) fsm_d = SNOOP;
      SNOOP:   fsm_d = (|wb_d) ? WB : DONE;
      WB:      fsm_d = DONE;
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      fsm_q  <= IDLE;
      rr_ptr <= IW'(NUM_CACHES - 1);
      win_q  <= '0;
      wr_q   <= '0;
      st_q   <= '0;
      ns_q   <= '0;
      wb_q   <= '0;
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      case (fsm_q)
        IDLE: if (|Request) begin
          win_q <= win_d;
          wr_q  <= WriteRead;
          st_q  <= State;
        end
        SNOOP: begin
          ns_q   <= ns_d;
          wb_q   <= wb_d;
          hit_q  <= hit_d;
          miss_q <= miss_d;
        end
        DONE:    rr_ptr <= win_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CACHES; i++) begin
      Grant[i] = (fsm_q != IDLE) && (IW'(i) == win_q);
    end
  end

  assign Busy      = (fsm_q != IDLE);
  assign Done      = (fsm_q == DONE);
  assign bus       = Busy ? cmd : BUS_NONE;
  assign WriteBack = (fsm_q == WB) ? wb_q : '0;
  assign NewState  = ns_q;
  assign Hit       = hit_q;
  assign Miss      = miss_q;

endmodule
